// File: rtl/aludec_pkg.sv
// Shared constants and types for the sequencing ALU decoder family.
// Opcode class codes and ALU operation codes are the 3-bit base encodings.
// Decoders with a wider ALU op field zero-extend them.
package aludec_pkg;

    // Opcode classes, indexed by opcode[2:0] when opcode[MSB] = 0
    localparam logic [2:0] OPC_LW  = 3'b000;
    localparam logic [2:0] OPC_SW  = 3'b001;
    localparam logic [2:0] OPC_BEQ = 3'b010;
    localparam logic [2:0] OPC_BNE = 3'b011;
    localparam logic [2:0] OPC_BLT = 3'b100;
    localparam logic [2:0] OPC_JMP = 3'b101;
    localparam logic [2:0] OPC_MUL = 3'b110;
    localparam logic [2:0] OPC_DIV = 3'b111;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD   = 3'b111;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_CMPEQ = 3'b101;
    localparam logic [2:0] ALU_CMPLT = 3'b100;
    localparam logic [2:0] ALU_PASS  = 3'b000;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SINGLE = 2'b01,
        BURST  = 2'b10
    } state_t;

    // Map a table-class opcode to its base ALU operation.
    // MUL runs add/shift steps and DIV runs sub/shift steps.
    function automatic logic [2:0] table_aluop(input logic [2:0] cls);
        logic [2:0] op;
        case (cls)
            OPC_LW:  op = ALU_ADD;
            OPC_SW:  op = ALU_ADD;
            OPC_BEQ: op = ALU_CMPEQ;
            OPC_BNE: op = ALU_CMPEQ;
            OPC_BLT: op = ALU_CMPLT;
            OPC_JMP: op = ALU_PASS;
            OPC_MUL: op = ALU_ADD;
            OPC_DIV: op = ALU_SUB;
            default: op = ALU_PASS;
        endcase
        return op;
    endfunction

    // True for the opcode classes that expand into a multi-step burst
    function automatic logic table_is_mc(input logic [2:0] cls);
        logic mc;
        case (cls)
            OPC_MUL: mc = 1'b1;
            OPC_DIV: mc = 1'b1;
            default: mc = 1'b0;
        endcase
        return mc;
    endfunction

endpackage

// File: rtl/aludec_table.sv
// Combinational opcode -> {aluop, is_multicycle} map.
// opcode[MSB] = 1 passes the low bits straight through as the ALU op.
// Otherwise the low three bits index the class table, and bits
// [ALUOP_W-1:3] play no part in the lookup.
module aludec_table
    import aludec_pkg::*;
#(
    parameter  int ALUOP_W  = 3,
    localparam int OPCODE_W = ALUOP_W + 1
) (
    input  logic [OPCODE_W-1:0] opcode,
    output logic [ALUOP_W-1:0]  aluop,
    output logic                is_multicycle
);

    // Decode the opcode into an ALU op and a burst flag
    always_comb begin
        aluop         = {ALUOP_W{1'b0}};
        is_multicycle = 1'b0;
        if (opcode[OPCODE_W-1]) begin
            aluop         = opcode[ALUOP_W-1:0];
            is_multicycle = 1'b0;
        end else begin
            aluop         = ALUOP_W'(table_aluop(opcode[2:0]));
            is_multicycle = table_is_mc(opcode[2:0]);
        end
    end

endmodule

// File: rtl/aludec_seq.sv
// Sequencing ALU decoder. It accepts one opcode per valid/ready handshake
// and presents a registered micro-op. MUL/DIV expand into MC_CYCLES
// micro-ops with an incrementing step index. A new opcode may be accepted
// in the same cycle as the final handshake of the previous one, so
// back-to-back instructions have no bubbles. flush discards everything in
// flight on the next edge.
module aludec_seq
    import aludec_pkg::*;
#(
    parameter  int ALUOP_W   = 3,
    parameter  int MC_CYCLES = 16,
    localparam int OPCODE_W  = ALUOP_W + 1,
    localparam int STEP_W    = $clog2(MC_CYCLES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ALUOP_W-1:0]  aluop,
    output logic [STEP_W-1:0]   step,
    output logic                last,
    output logic                busy
);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MC_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};

    state_t               state_r;
    state_t               next_state_s;

    logic                 out_valid_r;
    logic [ALUOP_W-1:0]   aluop_r;
    logic [STEP_W-1:0]    step_r;
    logic                 last_r;

    logic                 out_valid_s;
    logic [ALUOP_W-1:0]   aluop_s;
    logic [STEP_W-1:0]    step_s;
    logic                 last_s;

    logic [ALUOP_W-1:0]   tbl_aluop_s;
    logic                 tbl_mc_s;
    logic                 in_ready_s;
    logic                 accept_s;
    logic                 out_hs_s;
    logic [STEP_W-1:0]    step_inc_s;

    aludec_table #(
        .ALUOP_W (ALUOP_W)
    ) u_table (
        .opcode        (opcode),
        .aluop         (tbl_aluop_s),
        .is_multicycle (tbl_mc_s)
    );

    // Handshake qualifiers. A new opcode may enter only when the output
    // register will be free after this edge. In a burst that means the
    // final step is being consumed right now.
    always_comb begin
        in_ready_s = rst_n && !flush
                     && ((state_r != BURST) || (last_r && out_ready))
                     && (!out_valid_r || out_ready);
        accept_s   = in_valid && in_ready_s;
        out_hs_s   = out_valid_r && out_ready;
        step_inc_s = step_r + STEP_W'(1);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic. Flush overrides every handshake.
    always_comb begin
        next_state_s = state_r;
        if (flush) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        next_state_s = tbl_mc_s ? BURST : SINGLE;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                SINGLE: begin
                    if (accept_s) begin
                        next_state_s = tbl_mc_s ? BURST : SINGLE;
                    end else if (out_hs_s) begin
                        next_state_s = IDLE;
                    end else begin
                        next_state_s = SINGLE;
                    end
                end
                BURST: begin
                    if (accept_s) begin
                        next_state_s = tbl_mc_s ? BURST : SINGLE;
                    end else if (out_hs_s && last_r) begin
                        next_state_s = IDLE;
                    end else begin
                        next_state_s = BURST;
                    end
                end
                default: next_state_s = IDLE;
            endcase
        end
    end

    // Next value of the output register. It holds while stalled, loads on
    // accept and advances the step on a non-final burst handshake.
    always_comb begin
        out_valid_s = out_valid_r;
        aluop_s     = aluop_r;
        step_s      = step_r;
        last_s      = last_r;
        if (flush) begin
            out_valid_s = 1'b0;
            step_s      = STEP_ZERO;
            last_s      = 1'b0;
        end else if (accept_s) begin
            out_valid_s = 1'b1;
            aluop_s     = tbl_aluop_s;
            step_s      = STEP_ZERO;
            last_s      = !tbl_mc_s;
        end else if (out_hs_s) begin
            if (last_r) begin
                out_valid_s = 1'b0;
                step_s      = STEP_ZERO;
                last_s      = 1'b0;
            end else begin
                out_valid_s = 1'b1;
                step_s      = step_inc_s;
                last_s      = (step_inc_s == STEP_LAST);
            end
        end else begin
            out_valid_s = out_valid_r;
        end
    end

    // Output register. Reset drops any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            aluop_r     <= {ALUOP_W{1'b0}};
            step_r      <= STEP_ZERO;
            last_r      <= 1'b0;
        end else begin
            out_valid_r <= out_valid_s;
            aluop_r     <= aluop_s;
            step_r      <= step_s;
            last_r      <= last_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign aluop     = aluop_r;
    assign step      = step_r;
    assign last      = last_r;
    assign busy      = (state_r == BURST);

endmodule

// File: tb/tb_aludec_seq.sv
// Bench for aludec_seq with default parameters (ALUOP_W=3, MC_CYCLES=16).
// A queue model expands each accepted opcode into its expected micro-ops.
// The DUT is compared against the model every cycle. A log of consumed
// micro-ops is also checked against hand-written lists.
module tb_aludec_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] opcode = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] aluop;
    logic [3:0] step;
    logic       last;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] st;
        logic       ls;
    } uop_t;

    uop_t mq[$];      // model: micro-ops still owed for the current instruction
    bit   mq_mc;      // model: current instruction is a burst
    uop_t seen[$];    // micro-ops the DUT actually handed over

    always #5 clk = ~clk;

    aludec_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .aluop     (aluop),
        .step      (step),
        .last      (last),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Micro-op list for one opcode, straight from the decode table
    task automatic expand(input logic [3:0] opc);
        int n;
        logic [2:0] op;
        bit mc;
        n  = 1;
        mc = 1'b0;
        op = 3'd0;
        if (opc[3]) begin
            op = opc[2:0];
        end else begin
            case (opc[2:0])
                3'd0, 3'd1: op = 3'd7;
                3'd2, 3'd3: op = 3'd5;
                3'd4:       op = 3'd4;
                3'd5:       op = 3'd0;
                3'd6:       begin op = 3'd7; mc = 1'b1; n = 16; end
                default:    begin op = 3'd6; mc = 1'b1; n = 16; end
            endcase
        end
        mq_mc = mc;
        for (int i = 0; i < n; i++) begin
            mq.push_back('{op: op, st: 4'(i), ls: (i == n - 1)});
        end
    endtask

    // Per-cycle comparison against the model, then advance the model
    always @(negedge clk) begin
        bit exp_ir;
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_aluop", aluop, 0);
            chk("rst_step", step, 0);
            chk("rst_last", last, 0);
            chk("rst_busy", busy, 0);
            chk("rst_in_ready", in_ready, 0);
            mq.delete();
        end else begin
            exp_ir = !flush && (mq.size() == 0 || (mq.size() == 1 && out_ready));
            chk("in_ready", in_ready, exp_ir);
            chk("out_valid", out_valid, mq.size() > 0);
            chk("busy", busy, (mq.size() > 0) && mq_mc);
            if (mq.size() > 0) begin
                chk("aluop", aluop, mq[0].op);
                chk("step", step, mq[0].st);
                chk("last", last, mq[0].ls);
            end
            if (out_valid && out_ready && !flush) begin
                seen.push_back('{op: aluop, st: step, ls: last});
            end
            if (flush) begin
                mq.delete();
            end else begin
                if (mq.size() > 0 && out_ready) void'(mq.pop_front());
                if (in_valid && exp_ir) expand(opcode);
            end
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present an opcode until accepted. Optionally toggle out_ready each cycle.
    task automatic offer(input logic [3:0] opc, input bit tog, output int waits);
        bit got;
        got      = 1'b0;
        waits    = 0;
        in_valid = 1'b1;
        opcode   = opc;
        while (!got && waits < 200) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            @(posedge clk);
            #1;
            if (tog) out_ready = ~out_ready;
            if (!got) waits++;
        end
        in_valid = 1'b0;
        if (!got) chk("accept_timeout", 0, 1);
    endtask

    task automatic chk_seen(input string name, input int idx, input int op, input int st, input int ls);
        if (idx < seen.size()) begin
            chk({name, "_op"}, seen[idx].op, op);
            chk({name, "_step"}, seen[idx].st, st);
            chk({name, "_last"}, seen[idx].ls, ls);
        end else begin
            chk({name, "_missing"}, seen.size(), idx + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int tbl_exp[6];
        tbl_exp = '{7, 7, 5, 5, 4, 0};

        // Reset held with random inputs
        repeat (4) begin
            @(posedge clk);
            #1;
            in_valid  = 1'($urandom_range(0, 1));
            opcode    = 4'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            flush     = 1'($urandom_range(0, 1));
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", in_ready, 1);
        chk("post_reset_out_valid", out_valid, 0);
        @(posedge clk);
        #1;

        // Direct class streamed one per cycle
        seen.delete();
        for (int i = 8; i < 16; i++) begin
            offer(4'(i), 1'b0, w);
            chk("direct_nostall", w, 0);
        end
        idle(3);
        chk("direct_count", seen.size(), 8);
        for (int i = 0; i < 8; i++) chk_seen("direct", i, i, 0, 1);

        // Table class single ops
        seen.delete();
        for (int i = 0; i < 6; i++) begin
            offer(4'(i), 1'b0, w);
            chk("table_nostall", w, 0);
        end
        idle(3);
        chk("table_count", seen.size(), 6);
        for (int i = 0; i < 6; i++) chk_seen("table", i, tbl_exp[i], 0, 1);

        // MUL burst under 1,0,1,0 back-pressure with the next opcode waiting
        seen.delete();
        offer(4'b0110, 1'b0, w);
        offer(4'b1010, 1'b1, w);
        chk("mul_next_wait", w, 30);
        out_ready = 1'b1;
        idle(3);
        chk("mul_count", seen.size(), 17);
        for (int i = 0; i < 16; i++) chk_seen("mul", i, 7, i, (i == 15) ? 1 : 0);
        chk_seen("mul_next", 16, 2, 0, 1);

        // Flush while DIV step 5 is presented, with an opcode offered
        seen.delete();
        offer(4'b0111, 1'b0, w);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        opcode   = 4'b1001;
        @(negedge clk);
        chk("flush_step_shown", step, 5);
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_busy", busy, 0);
        chk("flush_step", step, 0);
        idle(3);
        chk("div_count", seen.size(), 5);
        for (int i = 0; i < 5; i++) chk_seen("div", i, 6, i, 0);

        // Reset while MUL step 9 is presented
        offer(4'b0110, 1'b0, w);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        chk("mid_step_shown", step, 9);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_step", step, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_aluop", aluop, 0);
        seen.delete();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        idle(5);
        chk("no_uop_after_reset", seen.size(), 0);
        offer(4'b1100, 1'b0, w);
        idle(2);
        chk("post_reset_count", seen.size(), 1);
        chk_seen("post_reset", 0, 4, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
